axis_pkt_capture: RTL and testbench
===================================

# axis_pkt_capture

Single-port AXI-Stream packet receiver and the counterpart of the per-port packet generators. On request it accepts exactly one packet from an AXIS slave port and assembles it into a flat MTU-wide byte vector. It reports the byte length, the first-beat `tuser` and an overflow flag. Tests and loopback checkers instantiate it, one per port, to compare received traffic against generated traffic.

## Interface
Parameters:
- `MTU_BYTES`, 1500: capacity of `packet_data` in bytes. Must be a multiple of `DATA_BYTES` (elaboration check).
- `DATA_BYTES`, 8: AXIS beat width in bytes. Must equal `axis_packet_in.DATA_BYTES` (elaboration check, `> 0`).

Ports:
- `clk` in 1: sole clock. `axis_packet_in.clk` must be the same net.
- `aresetn` in 1: reset, asynchronous, active-low. `axis_packet_in.sresetn` is unused.
- `axis_packet_in` AXIS_int.Slave: packet input. `tid` and `tdest` are ignored.
- `capture_req` in 1: single-cycle request to capture the next packet.
- `busy` out 1: high from request acceptance until `packet_done`.
- `packet_done` out 1: one-cycle pulse when a packet is complete.
- `packet_byte_length` out int: received byte count, saturated at `MTU_BYTES`.
- `packet_user` out `axis_packet_in.USER_WIDTH`: `tuser` of the first beat.
- `packet_data` out `MTU_BYTES*8`: byte k of the packet at bits `[8k+7:8k]`.
- `packet_overflow` out 1: the packet exceeded `MTU_BYTES`.
- `keep_error` out 1: present only with the macro (see Configuration). Tied 0 otherwise.

## Operation
- Reset values: all outputs 0, including `tready`. The state machine is in IDLE.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `tready`=0.
  - On `capture_req`, clear `packet_data`, `packet_byte_length`, `packet_overflow` and `keep_error`, zero the beat counter, set `busy`, then go to CAPTURE.
- CAPTURE:
  - `tready`=1.
  - Each accepted beat n (`tvalid&&tready`) writes `tdata` bytes whose `tkeep` bit is set to offset `n*DATA_BYTES`. Bytes with `tkeep`=0 stay 0.
  - Beat 0 latches `tuser` into `packet_user`.
  - On `tlast`:
    - `packet_byte_length` = `n*DATA_BYTES` + popcount(`tkeep`).
    - Go to IDLE, drop `busy` and pulse `packet_done`.
  - If beat `MTU_BYTES/DATA_BYTES` is accepted without `tlast`, its data is discarded, `packet_overflow` is set and the state goes to DRAIN.
- DRAIN:
  - `tready`=1. Beats are discarded.
  - On `tlast`: `packet_byte_length`=`MTU_BYTES`, go to IDLE and pulse `packet_done`.
- `capture_req` is ignored while `busy`=1.
- `capture_req` in the same cycle as `packet_done` is ignored; a new request is taken from the next cycle on.
- Beats presented while in IDLE are not accepted; they stall upstream.
- Results hold after `packet_done` until the next accepted `capture_req`.
- Beat counter width is `$clog2(MTU_BYTES/DATA_BYTES+1)`. It never wraps, because counting stops on entering DRAIN.
- Asserting `aresetn` low mid-packet: immediately return to IDLE with reset values. The partial packet is lost and no `packet_done` pulse occurs.

## Timing
- `tready` rises the cycle after `capture_req` is accepted. It is registered and glitch-free.
- `tready` falls the cycle after the `tlast` beat.
- `packet_done` pulses the cycle after the `tlast` handshake. `packet_byte_length`, `packet_user`, `packet_data` and the flags are valid in that same cycle.
- Throughput: one beat per cycle, with no bubbles inside a packet.
- A one-beat packet completes 2 cycles after the request, given `tvalid` is already high.

## Configuration
- `AXIS_PKT_CAPTURE_KEEP_CHECK_EN` defined: `keep_error` is set sticky for the current packet when either of these occurs:
  - a non-last beat has `tkeep`≠all-ones;
  - a last beat has non-contiguous `tkeep` (not of the form `2^m-1`, m≥1).
- Capture proceeds unchanged when `keep_error` is set.
- Macro undefined: the checker is not compiled and `keep_error` is constant 0.

## Test plan
All scenarios use `DATA_BYTES`=8 and `MTU_BYTES`=64.
- Reset, then hold `tvalid`=1 with no request → `tready` stays 0 and all outputs stay 0.
- Request, then a 20-byte packet (bytes 0x00..0x13, last `tkeep`=0x0F, first `tuser`=0x5) → `packet_done` 1 cycle after `tlast`:
  - length 20, user 0x5;
  - `packet_data[159:0]` matches the sent bytes and the upper bits are 0.
- Request, then a 64-byte packet with random `tvalid` gaps → length 64, no overflow, data matches.
- Request, then a 100-byte packet → first 64 bytes captured, `packet_overflow`=1, length 64, `packet_done` after the 13th beat (the `tlast` beat).
- Pulse `capture_req` mid-packet, then drop `aresetn` during beat 2 → the mid-packet request is ignored; after reset all outputs are 0, no `packet_done`, and a fresh request then captures the next packet correctly.
- With the macro defined, send beat 0 with `tkeep`=0xF7 (non-last), then a normal last beat → `keep_error`=1 and capture completes normally. Without the macro → `keep_error`=0.

Source files
------------

// File: rtl/axis_pkt_capture_if.sv
// ---------------------------------------------------------------------------
// AXIS_int : AXI-Stream bundle shared by the packet generators and capture
// blocks.
//   clk, sresetn : clock and synchronous active-low reset of the stream
//   tvalid/tready: handshake
//   tdata        : DATA_BYTES*8 payload bits, byte i at [8i+7:8i]
//   tkeep        : per-byte qualifier
//   tlast        : last beat of a packet
//   tuser/tid/tdest : sideband fields
// Modports: Master drives the stream, Slave receives it and drives tready.
// ---------------------------------------------------------------------------
interface AXIS_int #(
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1
) (
  input logic clk,
  input logic sresetn
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;

  modport Master (
    input  clk, sresetn, tready,
    output tvalid, tdata, tkeep, tlast, tuser, tid, tdest
  );

  modport Slave (
    input  clk, sresetn, tvalid, tdata, tkeep, tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/axis_pkt_capture.sv
// ---------------------------------------------------------------------------
// axis_pkt_capture : single-port AXI-Stream packet receiver.
// On a capture request it accepts exactly one packet and assembles it into a
// flat MTU-wide byte vector, reporting byte length, first-beat tuser and an
// overflow flag.
//
// Ports:
//   clk                : sole clock (axis_packet_in.clk must be the same net)
//   aresetn            : asynchronous active-low reset
//   axis_packet_in     : AXIS slave port (tid, tdest, sresetn ignored)
//   capture_req        : single-cycle request to capture the next packet
//   busy               : high from request acceptance until packet_done
//   packet_done        : one-cycle pulse when a packet is complete
//   packet_byte_length : received byte count, saturated at MTU_BYTES
//   packet_user        : tuser of the first beat
//   packet_data        : byte k of the packet at bits [8k+7:8k]
//   packet_overflow    : packet exceeded MTU_BYTES
//   keep_error         : tkeep sanity flag (constant 0 unless the checker
//                        is built)
//
// Optional feature macro: AXIS_PKT_CAPTURE_KEEP_CHECK_EN
//   When defined, keep_error is set sticky for the current packet when a
//   non-last beat has tkeep != all-ones or the last beat has a tkeep that is
//   not of the form 2^m-1 (m >= 1). Capture itself is unaffected.
// ---------------------------------------------------------------------------
module axis_pkt_capture #(
  parameter int MTU_BYTES  = 1500,
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  AXIS_int.Slave                 axis_packet_in,
  input  logic                   capture_req,
  output logic                   busy,
  output logic                   packet_done,
  output int                     packet_byte_length,
  output logic [USER_WIDTH-1:0]  packet_user,
  output logic [MTU_BYTES*8-1:0] packet_data,
  output logic                   packet_overflow,
  output logic                   keep_error
);

  localparam int MAX_BEATS = MTU_BYTES / DATA_BYTES;
  // One extra count so the first beat past the MTU is distinguishable.
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] OVF_BEAT  = BEAT_W'(MAX_BEATS);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};

  // Elaboration-time parameter consistency checks.
  if (DATA_BYTES <= 0) begin : g_chk_db_pos
    $error("axis_pkt_capture: DATA_BYTES must be > 0");
  end
  if ((MTU_BYTES % DATA_BYTES) != 0) begin : g_chk_mtu_mult
    $error("axis_pkt_capture: MTU_BYTES must be a multiple of DATA_BYTES");
  end
  if (axis_packet_in.DATA_BYTES != DATA_BYTES) begin : g_chk_db_if
    $error("axis_pkt_capture: DATA_BYTES differs from the interface");
  end
  if (axis_packet_in.USER_WIDTH != USER_WIDTH) begin : g_chk_uw_if
    $error("axis_pkt_capture: USER_WIDTH differs from the interface");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Number of set tkeep bits, i.e. valid bytes in a (last) beat.
  function automatic int popcount(input logic [DATA_BYTES-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      cnt = cnt + int'(keep[i]);
    end
    return cnt;
  endfunction

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tready_q, tready_d;
  int                     len_q, len_d;
  logic [USER_WIDTH-1:0]  user_q, user_d;
  logic [MTU_BYTES*8-1:0] data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;

  logic hs_s;
  logic req_accept_s;
  logic unused_ok_s;

  // tready_q is only ever high in CAPTURE or DRAIN, so hs_s implies one of them.
  assign hs_s = axis_packet_in.tvalid && tready_q;
  // A request coinciding with packet_done is dropped; busy implies not IDLE.
  assign req_accept_s = (state_q == ST_IDLE) && capture_req && !done_q;

  assign unused_ok_s = ^{axis_packet_in.clk, axis_packet_in.sresetn,
                         axis_packet_in.tid, axis_packet_in.tdest};

  // Next-state and result computation for the capture FSM.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tready_d = tready_q;
    len_d    = len_q;
    user_d   = user_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    beat_d   = beat_q;

    case (state_q)
      ST_IDLE: begin
        if (req_accept_s) begin
          data_d   = {(MTU_BYTES*8){1'b0}};
          len_d    = 0;
          ovf_d    = 1'b0;
          beat_d   = BEAT_ZERO;
          busy_d   = 1'b1;
          tready_d = 1'b1;
          state_d  = ST_CAPTURE;
        end else begin
          tready_d = 1'b0;
          busy_d   = 1'b0;
        end
      end

      ST_CAPTURE: begin
        if (hs_s) begin
          if (beat_q == OVF_BEAT) begin
            // Beat beyond the MTU: data is dropped.
            ovf_d = 1'b1;
            if (axis_packet_in.tlast) begin
              len_d    = MTU_BYTES;
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              tready_d = 1'b0;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (axis_packet_in.tkeep[i]) begin
                data_d[(int'(beat_q) * DATA_BYTES + i) * 8 +: 8] =
                  axis_packet_in.tdata[i * 8 +: 8];
              end else begin
                data_d[(int'(beat_q) * DATA_BYTES + i) * 8 +: 8] = 8'h00;
              end
            end
            if (beat_q == BEAT_ZERO) begin
              user_d = axis_packet_in.tuser;
            end else begin
              user_d = user_q;
            end
            if (axis_packet_in.tlast) begin
              len_d    = int'(beat_q) * DATA_BYTES + popcount(axis_packet_in.tkeep);
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              tready_d = 1'b0;
            end else begin
              beat_d = beat_q + BEAT_W'(1'b1);
            end
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_DRAIN: begin
        if (hs_s && axis_packet_in.tlast) begin
          len_d    = MTU_BYTES;
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          tready_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        tready_d = 1'b0;
      end
    endcase
  end

  // Capture FSM state and result registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tready_q <= 1'b0;
      len_q    <= 0;
      user_q   <= {USER_WIDTH{1'b0}};
      data_q   <= {(MTU_BYTES*8){1'b0}};
      ovf_q    <= 1'b0;
      beat_q   <= BEAT_ZERO;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tready_q <= tready_d;
      len_q    <= len_d;
      user_q   <= user_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      beat_q   <= beat_d;
    end
  end

`ifdef AXIS_PKT_CAPTURE_KEEP_CHECK_EN
  localparam logic [DATA_BYTES-1:0] KEEP_ALL = {DATA_BYTES{1'b1}};
  localparam logic [DATA_BYTES-1:0] KEEP_ONE = DATA_BYTES'(1'b1);

  // A last beat must be 2^m-1 (m >= 1): non-zero, and adding one clears all bits.
  function automatic logic keep_bad(input logic [DATA_BYTES-1:0] keep,
                                    input logic                  last);
    logic bad;
    if (last) begin
      bad = (keep == {DATA_BYTES{1'b0}}) ||
            ((keep & (keep + KEEP_ONE)) != {DATA_BYTES{1'b0}});
    end else begin
      bad = (keep != KEEP_ALL);
    end
    return bad;
  endfunction

  logic kerr_q, kerr_d;

  // Sticky per-packet tkeep error, cleared on each accepted request.
  always_comb begin
    kerr_d = kerr_q;
    if (req_accept_s) begin
      kerr_d = 1'b0;
    end else if (hs_s && keep_bad(axis_packet_in.tkeep, axis_packet_in.tlast)) begin
      kerr_d = 1'b1;
    end else begin
      kerr_d = kerr_q;
    end
  end

  // tkeep error flag register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      kerr_q <= 1'b0;
    end else begin
      kerr_q <= kerr_d;
    end
  end

  assign keep_error = kerr_q;
`else
  assign keep_error = 1'b0;
`endif

  assign axis_packet_in.tready = tready_q;
  assign busy                  = busy_q;
  assign packet_done           = done_q;
  assign packet_byte_length    = len_q;
  assign packet_user           = user_q;
  assign packet_data           = data_q;
  assign packet_overflow       = ovf_q;

endmodule

// File: tb/tb_axis_pkt_capture.sv
// Directed testbench for axis_pkt_capture with DATA_BYTES=8, MTU_BYTES=64.
module tb_axis_pkt_capture;

`ifdef AXIS_PKT_CAPTURE_KEEP_CHECK_EN
  localparam logic KEEP_CHECK = 1'b1;
`else
  localparam logic KEEP_CHECK = 1'b0;
`endif

  logic         clk;
  logic         aresetn;
  logic         capture_req;
  logic         busy;
  logic         packet_done;
  int           packet_byte_length;
  logic [7:0]   packet_user;
  logic [511:0] packet_data;
  logic         packet_overflow;
  logic         keep_error;

  int checks;
  int errors;
  int done_cnt;
  int done_saved;
  logic [511:0] exp_data;
  logic [63:0]  d;

  AXIS_int #(.DATA_BYTES(8), .USER_WIDTH(8)) axis_if (.clk(clk), .sresetn(aresetn));

  axis_pkt_capture #(.MTU_BYTES(64), .DATA_BYTES(8), .USER_WIDTH(8)) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .axis_packet_in     (axis_if),
    .capture_req        (capture_req),
    .busy               (busy),
    .packet_done        (packet_done),
    .packet_byte_length (packet_byte_length),
    .packet_user        (packet_user),
    .packet_data        (packet_data),
    .packet_overflow    (packet_overflow),
    .keep_error         (keep_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which packet_done was high.
  always @(posedge clk) begin
    if (packet_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic beat(input logic [63:0] bd, input logic [7:0] bk, input logic bl, input logic [7:0] bu);
    int t;
    t = 0;
    axis_if.tvalid = 1'b1;
    axis_if.tdata  = bd;
    axis_if.tkeep  = bk;
    axis_if.tlast  = bl;
    axis_if.tuser  = bu;
    @(negedge clk);
    while (axis_if.tready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $error("FAIL hs_timeout observed=no_tready expected=tready");
    end
    @(posedge clk); #1;
    axis_if.tvalid = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic request();
    capture_req = 1'b1;
    @(posedge clk); #1;
    capture_req = 1'b0;
    @(negedge clk);
    chk("req_tready", axis_if.tready, 512'd1);
    chk("req_busy", busy, 512'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    aresetn = 1'b0; capture_req = 1'b0;
    axis_if.tvalid = 1'b0; axis_if.tdata = 64'd0; axis_if.tkeep = 8'd0;
    axis_if.tlast = 1'b0; axis_if.tuser = 8'd0; axis_if.tid = 1'b0; axis_if.tdest = 1'b0;

    // Reset, then tvalid held high with no request.
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    axis_if.tvalid = 1'b1; axis_if.tdata = 64'hDEADBEEFCAFEF00D;
    axis_if.tkeep = 8'hFF; axis_if.tlast = 1'b1; axis_if.tuser = 8'h0F;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_tready", axis_if.tready, 512'd0);
    chk("idle_busy", busy, 512'd0);
    chk("idle_done_cnt", done_cnt, 512'd0);
    chk("idle_len", packet_byte_length, 512'd0);
    chk("idle_user", packet_user, 512'd0);
    chk("idle_data", packet_data, 512'd0);
    chk("idle_ovf", packet_overflow, 512'd0);
    chk("idle_kerr", keep_error, 512'd0);
    @(posedge clk); #1;
    axis_if.tvalid = 1'b0;

    // 20-byte packet, bytes 0x00..0x13, last tkeep 0x0F.
    request();
    beat(64'h0706050403020100, 8'hFF, 1'b0, 8'h05);
    beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 8'h0A);
    beat(64'hAAAAAAAA13121110, 8'h0F, 1'b1, 8'h0B);
    exp_data = 512'd0;
    for (int k = 0; k < 20; k++) exp_data[8*k +: 8] = 8'(k);
    @(negedge clk);
    chk("p20_done", packet_done, 512'd1);
    chk("p20_len", packet_byte_length, 512'd20);
    chk("p20_user", packet_user, 512'h05);
    chk("p20_data", packet_data, exp_data);
    chk("p20_ovf", packet_overflow, 512'd0);
    chk("p20_kerr", keep_error, 512'd0);
    chk("p20_busy", busy, 512'd0);
    chk("p20_tready", axis_if.tready, 512'd0);
    @(negedge clk);
    chk("p20_done_pulse", packet_done, 512'd0);
    chk("p20_len_hold", packet_byte_length, 512'd20);
    @(posedge clk); #1;

    // 64-byte packet with tvalid gaps; request during packet_done is dropped.
    request();
    exp_data = 512'd0;
    for (int k = 0; k < 64; k++) exp_data[8*k +: 8] = 8'(k) ^ 8'hA5;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = exp_data[8*(8*i+j) +: 8];
      repeat (i % 3) begin @(posedge clk); #1; end
      beat(d, 8'hFF, (i == 7), (i == 0) ? 8'h02 : 8'h33);
    end
    capture_req = 1'b1;
    @(negedge clk);
    chk("p64_done", packet_done, 512'd1);
    chk("p64_len", packet_byte_length, 512'd64);
    chk("p64_user", packet_user, 512'h02);
    chk("p64_data", packet_data, exp_data);
    chk("p64_ovf", packet_overflow, 512'd0);
    @(posedge clk); #1;
    capture_req = 1'b0;
    @(negedge clk);
    chk("req_on_done_busy", busy, 512'd0);
    chk("req_on_done_tready", axis_if.tready, 512'd0);
    chk("req_on_done_len", packet_byte_length, 512'd64);
    @(posedge clk); #1;

    // 100-byte packet: 13 beats, only the first 64 bytes kept.
    request();
    done_saved = done_cnt;
    exp_data = 512'd0;
    for (int k = 0; k < 64; k++) exp_data[8*k +: 8] = 8'(k + 1);
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(8*i + j + 1);
      beat(d, (i == 12) ? 8'h0F : 8'hFF, (i == 12), (i == 0) ? 8'h07 : 8'h44);
    end
    @(negedge clk);
    chk("p100_done", packet_done, 512'd1);
    chk("p100_no_early_done", done_cnt, done_saved);
    chk("p100_len", packet_byte_length, 512'd64);
    chk("p100_ovf", packet_overflow, 512'd1);
    chk("p100_user", packet_user, 512'h07);
    chk("p100_data", packet_data, exp_data);
    @(posedge clk); #1;

    // Mid-packet request ignored, then reset during beat 2.
    request();
    done_saved = done_cnt;
    beat(64'h1111111111111111, 8'hFF, 1'b0, 8'h06);
    capture_req = 1'b1;
    beat(64'h2222222222222222, 8'hFF, 1'b0, 8'h06);
    capture_req = 1'b0;
    @(negedge clk);
    chk("mid_req_busy", busy, 512'd1);
    chk("mid_req_tready", axis_if.tready, 512'd1);
    axis_if.tvalid = 1'b1; axis_if.tdata = 64'h3333333333333333;
    axis_if.tkeep = 8'hFF; axis_if.tlast = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_tready", axis_if.tready, 512'd0);
    chk("rst_busy", busy, 512'd0);
    chk("rst_done", packet_done, 512'd0);
    chk("rst_len", packet_byte_length, 512'd0);
    chk("rst_user", packet_user, 512'd0);
    chk("rst_data", packet_data, 512'd0);
    chk("rst_ovf", packet_overflow, 512'd0);
    @(posedge clk); #1;
    axis_if.tvalid = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_no_done", done_cnt, done_saved);
    chk("rst_idle_busy", busy, 512'd0);
    @(posedge clk); #1;

    // Fresh one-beat packet with tvalid already high: done 2 cycles after request.
    capture_req = 1'b1;
    axis_if.tvalid = 1'b1; axis_if.tdata = 64'h00000000_00C3C2C1;
    axis_if.tkeep = 8'h07; axis_if.tlast = 1'b1; axis_if.tuser = 8'h03;
    @(posedge clk); #1;
    capture_req = 1'b0;
    @(negedge clk);
    chk("one_beat_not_yet", packet_done, 512'd0);
    @(posedge clk); #1;
    axis_if.tvalid = 1'b0;
    @(negedge clk);
    chk("one_beat_done", packet_done, 512'd1);
    chk("one_beat_len", packet_byte_length, 512'd3);
    chk("one_beat_user", packet_user, 512'h03);
    chk("one_beat_data", packet_data, 512'hC3C2C1);
    @(posedge clk); #1;

    // Non-last beat with tkeep 0xF7, then a full last beat.
    request();
    beat(64'h1122334455667788, 8'hF7, 1'b0, 8'h09);
    beat(64'h99AABBCCDDEEFF00, 8'hFF, 1'b1, 8'h01);
    exp_data = {384'd0, 64'h99AABBCCDDEEFF00, 64'h1122334400667788};
    @(negedge clk);
    chk("keep_done", packet_done, 512'd1);
    chk("keep_len", packet_byte_length, 512'd16);
    chk("keep_data", packet_data, exp_data);
    chk("keep_user", packet_user, 512'h09);
    chk("keep_err", keep_error, {511'd0, KEEP_CHECK});
    @(posedge clk); #1;

    // The next accepted request clears keep_error.
    request();
    chk("keep_err_clear", keep_error, 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
